// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped instruction cache, 2^INDEX_BITS lines of
//             LINE_WORDS x 32-bit words. Hits are resolved combinationally;
//             misses refill the whole line from memory one word at a time.
//  Ports    : clk, rst         - clock, asynchronous active-high reset
//             i_rdy            - global ready, 0 freezes all state
//             i_fetch_req/pc   - fetch request (level) and word address
//             o_instr_valid    - o_instr_out holds the word at i_fetch_pc
//             o_instr_out      - instruction word
//             o_mem_req/addr   - word read request / address to memory
//             i_mem_valid/data - one-cycle response pulse / returned word
//  Revision : 1.0  initial release
// ============================================================================
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rdy,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr_out,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_data
);

  localparam int c_LINES = 1 << INDEX_BITS;
  localparam int c_TAG_W = 32 - INDEX_BITS - 4;

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_REFILL = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;

  logic [c_LINES-1:0] r_valid;
  logic [c_TAG_W-1:0] r_tag  [c_LINES];
  logic [31:0]        r_data [c_LINES][LINE_WORDS];

  // Holds the first LINE_WORDS-1 words of a refill; the last word is taken
  // straight from i_mem_data on the completing edge.
  logic [31:0]        r_buf  [LINE_WORDS-1];
  logic [1:0]         r_cnt;
  // During a refill bits [31:4] are the line base and bits [3:2] track the
  // word being requested, so the index/tag of the line being filled are
  // read back from this register.
  logic [31:0]        r_mem_addr;

  logic [INDEX_BITS-1:0] w_idx;
  logic [1:0]            w_word;
  logic [c_TAG_W-1:0]    w_tag;
  logic [INDEX_BITS-1:0] w_ref_idx;
  logic [c_TAG_W-1:0]    w_ref_tag;
  logic                  w_hit;
  logic                  w_start;
  logic                  w_beat;
  logic                  w_done;
  logic                  w_unused;

  assign w_idx     = i_fetch_pc[INDEX_BITS+3:4];
  assign w_word    = i_fetch_pc[3:2];
  assign w_tag     = i_fetch_pc[31:INDEX_BITS+4];
  assign w_ref_idx = r_mem_addr[INDEX_BITS+3:4];
  assign w_ref_tag = r_mem_addr[31:INDEX_BITS+4];
  assign w_unused  = &{1'b0, i_fetch_pc[1:0]};

  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_start = (r_state == c_ST_IDLE) && i_rdy && i_fetch_req && !w_hit;
  // Responses are only accepted while refilling and not paused.
  assign w_beat  = (r_state == c_ST_REFILL) && i_rdy && i_mem_valid;
  assign w_done  = w_beat && (r_cnt == 2'd3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_start) w_state_nxt = c_ST_REFILL;
      c_ST_REFILL: if (w_done)  w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_mem_req     = (r_state == c_ST_REFILL);
    o_mem_addr    = r_mem_addr;
    o_instr_valid = i_rdy && i_fetch_req && w_hit;
    o_instr_out   = r_data[w_idx][w_word];
  end

  // Refill bookkeeping and valid bits. The target line is invalidated as the
  // refill starts and only re-validated together with the final word, so a
  // half-written line can never produce a hit, and a reset mid-refill leaves
  // it invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      for (int i = 0; i < LINE_WORDS - 1; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_start) begin
      r_valid[w_idx] <= 1'b0;
      r_cnt          <= '0;
      r_mem_addr     <= {i_fetch_pc[31:4], 4'b0000};
    end else if (w_beat) begin
      r_cnt <= r_cnt + 2'd1;
      if (w_done) begin
        // Address stays on the last word of the line; it never wraps.
        r_valid[w_ref_idx] <= 1'b1;
      end else begin
        r_buf[r_cnt]     <= i_mem_data;
        r_mem_addr[3:2]  <= r_cnt + 2'd1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_done) begin
      r_tag[w_ref_idx] <= w_ref_tag;
      for (int i = 0; i < LINE_WORDS - 1; i++) begin
        r_data[w_ref_idx][i] <= r_buf[i];
      end
      r_data[w_ref_idx][LINE_WORDS-1] <= i_mem_data;
    end
  end

endmodule
`default_nettype wire
